// File: rtl/instr_ram_loader.sv
// ---------------------------------------------------------------------------
// instr_ram_loader
//
// Boot-time writer for the instruction RAM. A framed byte stream from the
// debug UART (MAGIC, LEN_LO, LEN_HI, 4*N payload bytes, CSUM) is assembled
// into little-endian 32-bit words that are written to consecutive RAM word
// addresses starting at 0. The CPU is held in reset (and the RAM port is
// owned by this block) until a frame completes with a matching checksum.
//
// Ports:
//   clk_i           system clock
//   resetn_i        asynchronous active-low reset
//   rx_valid_i      byte available from the UART receiver
//   rx_data_i       received byte
//   rx_ready_o      loader can take a byte (transfer on valid & ready)
//   ram_ce_o        RAM clock enable, high only during a word write
//   ram_wre_o       RAM write enable, high only during a word write
//   ram_ad_o        RAM word address
//   ram_din_o       RAM write data
//   cpu_hold_o      hold CPU in reset and give the RAM port to the loader
//   load_done_o     last frame loaded and checksum matched
//   load_err_o      last frame aborted (bad length, checksum or timeout)
//   words_loaded_o  words written in the current/last frame
// ---------------------------------------------------------------------------
module instr_ram_loader #(
    parameter int          ADDR_W  = 12,
    parameter int          DATA_W  = 32,
    parameter logic [7:0]  MAGIC   = 8'hA5,
    parameter int          TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              ram_ce_o,
    output logic              ram_wre_o,
    output logic [ADDR_W-1:0] ram_ad_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                rx_ready_q, rx_ready_d;
    logic                ram_ce_q, ram_ce_d;
    logic                ram_wre_q, ram_wre_d;
    logic [ADDR_W-1:0]   ram_ad_q, ram_ad_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [7:0]          csum_q, csum_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   word_q, word_d;

    logic                accept_s;
    logic                tmo_hit_s;
    logic [15:0]         len_s;
    logic [DATA_W-1:0]   word_s;

    // Byte handshake and the idle-cycle limit inside a frame.
    always_comb begin
        accept_s  = rx_valid_i & rx_ready_q;
        tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT - 1));
    end

    // Frame parser: next state and next values of every register.
    always_comb begin
        state_d     = state_q;
        rx_ready_d  = 1'b1;
        ram_ce_d    = 1'b0;
        ram_wre_d   = 1'b0;
        ram_ad_d    = ram_ad_q;
        ram_din_d   = ram_din_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        words_d     = words_q;
        csum_d      = csum_q;
        tmo_d       = '0;
        len_d       = len_q;
        idx_d       = idx_q;
        word_d      = word_q;
        len_s       = {rx_data_i, len_q[7:0]};
        word_s      = word_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Only MAGIC starts a frame; anything else is dropped.
                if (accept_s && (rx_data_i == MAGIC)) begin
                    state_d     = S_LEN0;
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    words_d     = '0;
                    csum_d      = 8'd0;
                    ram_ad_d    = '0;
                    idx_d       = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end

            S_LEN0: begin
                if (accept_s) begin
                    len_d   = {8'd0, rx_data_i};
                    state_d = S_LEN1;
                end else if (tmo_hit_s) begin
                    state_d    = S_ERR;
                    load_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_LEN1: begin
                if (accept_s) begin
                    len_d = len_s;
                    // A frame must hold at least one word and fit in the RAM.
                    if ((len_s == 16'd0) || (32'(len_s) > (32'd1 << ADDR_W))) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 2'd0;
                    end
                end else if (tmo_hit_s) begin
                    state_d    = S_ERR;
                    load_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_DATA: begin
                if (accept_s) begin
                    word_s[{idx_q, 3'b000} +: 8] = rx_data_i;
                    word_d = word_s;
                    csum_d = csum_q + rx_data_i;
                    idx_d  = idx_q + 2'd1;
                    // Fourth byte: present the complete word to the RAM
                    // next cycle and pause the UART for that one cycle.
                    if (idx_q == 2'd3) begin
                        state_d    = S_WRITE;
                        ram_ce_d   = 1'b1;
                        ram_wre_d  = 1'b1;
                        ram_din_d  = word_s;
                        rx_ready_d = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (tmo_hit_s) begin
                    state_d    = S_ERR;
                    load_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_WRITE: begin
                words_d  = words_q + (ADDR_W + 1)'(1);
                // Wraps to 0 only after the 2^ADDR_W-th word.
                ram_ad_d = ram_ad_q + ADDR_W'(1);
                if ((32'(words_q) + 32'd1) == 32'(len_q)) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end

            S_CSUM: begin
                if (accept_s) begin
                    if (rx_data_i == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_d    = S_ERR;
                    load_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b1;
            ram_ce_q    <= 1'b0;
            ram_wre_q   <= 1'b0;
            ram_ad_q    <= '0;
            ram_din_q   <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            words_q     <= '0;
            csum_q      <= 8'd0;
            tmo_q       <= '0;
            len_q       <= 16'd0;
            idx_q       <= 2'd0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            ram_ce_q    <= ram_ce_d;
            ram_wre_q   <= ram_wre_d;
            ram_ad_q    <= ram_ad_d;
            ram_din_q   <= ram_din_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            words_q     <= words_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
        end
    end

    assign rx_ready_o     = rx_ready_q;
    assign ram_ce_o       = ram_ce_q;
    assign ram_wre_o      = ram_wre_q;
    assign ram_ad_o       = ram_ad_q;
    assign ram_din_o      = ram_din_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign load_done_o    = load_done_q;
    assign load_err_o     = load_err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_instr_ram_loader.sv
// ---------------------------------------------------------------------------
// Testbench for instr_ram_loader: directed frames from the test plan plus
// randomized frames checked against a byte-level model of the frame format.
// ---------------------------------------------------------------------------
module tb_instr_ram_loader;

    localparam int ADDR_W = 12;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              ram_ce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [31:0]       ram_din;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]        frame_q[$];
    logic [7:0]        pl_q[$];
    logic [ADDR_W-1:0] wad_q[$];
    logic [31:0]       wdin_q[$];
    logic [31:0]       mem [0:4095];
    int                nready_cnt = 0;
    int                viol_cnt   = 0;
    bit                exp_ok;

    instr_ram_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (32),
        .MAGIC  (8'hA5),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .rx_ready_o    (rx_ready),
        .ram_ce_o      (ram_ce),
        .ram_wre_o     (ram_wre),
        .ram_ad_o      (ram_ad),
        .ram_din_o     (ram_din),
        .cpu_hold_o    (cpu_hold),
        .load_done_o   (load_done),
        .load_err_o    (load_err),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    // RAM model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (ram_ce && ram_wre) begin
                mem[ram_ad] = ram_din;
                wad_q.push_back(ram_ad);
                wdin_q.push_back(ram_din);
            end
            if (!rx_ready) nready_cnt++;
            if (((!rx_ready) != (ram_ce && ram_wre)) || (ram_ce != ram_wre)) viol_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Offer one byte and wait until the loader takes it; leaves rx_valid high.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            tests_run++; tests_failed++;
            $display("FAIL send_byte: rx_ready stuck low for byte %h", b);
        end
        @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        rx_valid = 1'b0;
    endtask

    // Reference model: random payload of n words, checksum = byte sum mod 256.
    task automatic build_frame(input int n, input bit bad, input bit force_magic);
        int sum = 0;
        logic [7:0] b;
        logic [15:0] n16;
        n16 = n[15:0];
        pl_q.delete();
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(n16[7:0]);
        frame_q.push_back(n16[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            if (force_magic && i == 0) b = 8'hA5;
            pl_q.push_back(b);
            frame_q.push_back(b);
            sum += int'(b);
        end
        b = 8'(sum % 256);
        if (bad) b = b + 8'd1;
        frame_q.push_back(b);
        exp_ok = !bad;
    endtask

    function automatic logic [31:0] model_word(input int k);
        return 32'(int'(pl_q[4*k]) + int'(pl_q[4*k+1]) * 256 +
                   int'(pl_q[4*k+2]) * 65536) + (32'(pl_q[4*k+3]) << 24);
    endfunction

    task automatic test_reset();
        resetn = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        tests_run++; if (ram_ce !== 1'b0) begin tests_failed++; $display("FAIL rst_ram_ce: got %b want 0", ram_ce); end
        tests_run++; if (ram_wre !== 1'b0) begin tests_failed++; $display("FAIL rst_ram_wre: got %b want 0", ram_wre); end
        tests_run++; if (ram_ad !== 12'd0) begin tests_failed++; $display("FAIL rst_ram_ad: got %h want 0", ram_ad); end
        tests_run++; if (ram_din !== 32'd0) begin tests_failed++; $display("FAIL rst_ram_din: got %h want 0", ram_din); end
        tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("FAIL rst_load_done: got %b want 0", load_done); end
        tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("FAIL rst_load_err: got %b want 0", load_err); end
        tests_run++; if (words_loaded !== 13'd0) begin tests_failed++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
    endtask

    task automatic test_directed(input logic [7:0] cs, input bit good);
        int wb = wad_q.size();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h78, 8'h56, 8'h34, 8'h12, cs};
        send_frame();
        tests_run++; if (wad_q.size() - wb != 2) begin tests_failed++; $display("FAIL dir_wcount: got %0d want 2", wad_q.size() - wb); end
        if (wad_q.size() - wb >= 2) begin
            tests_run++; if (wad_q[wb] !== 12'd0 || wdin_q[wb] !== 32'h00000013) begin tests_failed++; $display("FAIL dir_w0: got ad=%h din=%h want ad=0 din=00000013", wad_q[wb], wdin_q[wb]); end
            tests_run++; if (wad_q[wb+1] !== 12'd1 || wdin_q[wb+1] !== 32'h12345678) begin tests_failed++; $display("FAIL dir_w1: got ad=%h din=%h want ad=1 din=12345678", wad_q[wb+1], wdin_q[wb+1]); end
        end
        tests_run++; if (load_done !== good) begin tests_failed++; $display("FAIL dir_done: got %b want %b", load_done, good); end
        tests_run++; if (load_err !== !good) begin tests_failed++; $display("FAIL dir_err: got %b want %b", load_err, !good); end
        tests_run++; if (cpu_hold !== !good) begin tests_failed++; $display("FAIL dir_hold: got %b want %b", cpu_hold, !good); end
        tests_run++; if (words_loaded !== 13'd2) begin tests_failed++; $display("FAIL dir_words: got %0d want 2", words_loaded); end
        tests_run++; if (ram_ad !== 12'd2) begin tests_failed++; $display("FAIL dir_ram_ad: got %0d want 2", ram_ad); end
    endtask

    task automatic test_len_errors();
        int wb = wad_q.size();
        frame_q = '{8'h00, 8'hFF};
        send_frame();
        tests_run++; if (load_err !== 1'b1 || words_loaded !== 13'd2) begin tests_failed++; $display("FAIL junk_ignored: got err=%b words=%0d want err=1 words=2", load_err, words_loaded); end
        frame_q = '{8'hA5};
        send_frame();
        tests_run++; if (load_err !== 1'b0 || words_loaded !== 13'd0 || cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL magic_clear: got err=%b words=%0d hold=%b want 0 0 1", load_err, words_loaded, cpu_hold); end
        frame_q = '{8'h00, 8'h00};
        send_frame();
        tests_run++; if (load_err !== 1'b1 || load_done !== 1'b0) begin tests_failed++; $display("FAIL len0_err: got err=%b done=%b want 1 0", load_err, load_done); end
        frame_q = '{8'hA5, 8'h01, 8'h10};
        send_frame();
        tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("FAIL len4097_err: got %b want 1", load_err); end
        repeat (2) @(negedge clk);
        tests_run++; if (wad_q.size() != wb) begin tests_failed++; $display("FAIL len_nowrite: got %0d writes want 0", wad_q.size() - wb); end
    endtask

    task automatic test_timeout();
        int wb;
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_frame();
        repeat (TMO - 1) @(negedge clk);
        tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("FAIL tmo_early: got err=%b want 0", load_err); end
        @(negedge clk);
        tests_run++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL tmo_err: got err=%b hold=%b want 1 1", load_err, cpu_hold); end
        wb = wad_q.size();
        build_frame(2, 1'b0, 1'b0);
        send_frame();
        tests_run++; if (load_done !== 1'b1 || wad_q.size() - wb != 2) begin tests_failed++; $display("FAIL tmo_recover: got done=%b writes=%0d want 1 2", load_done, wad_q.size() - wb); end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 5; it++) begin
            int n = (it == 0) ? 1 : int'($urandom_range(2, 24));
            int wb = wad_q.size();
            int nr = nready_cnt;
            int bad = 0;
            build_frame(n, (it == 2), (it == 3));
            send_frame();
            tests_run++; if (wad_q.size() - wb != n) begin tests_failed++; $display("FAIL b2b_wcount[%0d]: got %0d want %0d", it, wad_q.size() - wb, n); end
            for (int k = 0; k < n && wb + k < wad_q.size(); k++)
                if (wad_q[wb+k] !== 12'(k) || wdin_q[wb+k] !== model_word(k)) bad++;
            tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL b2b_words[%0d]: got %0d wrong words want 0", it, bad); end
            tests_run++; if (nready_cnt - nr != n) begin tests_failed++; $display("FAIL b2b_stall[%0d]: got %0d low cycles want %0d", it, nready_cnt - nr, n); end
            tests_run++; if (load_done !== exp_ok || load_err !== !exp_ok) begin tests_failed++; $display("FAIL b2b_status[%0d]: got done=%b err=%b want %b %b", it, load_done, load_err, exp_ok, !exp_ok); end
            tests_run++; if (words_loaded !== 13'(n)) begin tests_failed++; $display("FAIL b2b_wl[%0d]: got %0d want %0d", it, words_loaded, n); end
        end
        tests_run++; if (viol_cnt != 0) begin tests_failed++; $display("FAIL strobe_rules: got %0d violations want 0", viol_cnt); end
    endtask

    task automatic test_full_load();
        int wb = wad_q.size();
        int nr = nready_cnt;
        int bad = 0;
        build_frame(4096, 1'b0, 1'b0);
        send_frame();
        tests_run++; if (wad_q.size() - wb != 4096) begin tests_failed++; $display("FAIL full_wcount: got %0d want 4096", wad_q.size() - wb); end
        if (wad_q.size() > 0) begin
            tests_run++; if (wad_q[wad_q.size()-1] !== 12'd4095) begin tests_failed++; $display("FAIL full_last_ad: got %0d want 4095", wad_q[wad_q.size()-1]); end
        end
        for (int k = 0; k < 4096; k++) if (mem[k] !== model_word(k)) bad++;
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL full_mem: got %0d wrong words want 0", bad); end
        tests_run++; if (words_loaded !== 13'd4096) begin tests_failed++; $display("FAIL full_wl: got %0d want 4096", words_loaded); end
        tests_run++; if (ram_ad !== 12'd0) begin tests_failed++; $display("FAIL full_ad_wrap: got %0d want 0", ram_ad); end
        tests_run++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin tests_failed++; $display("FAIL full_done: got done=%b hold=%b want 1 0", load_done, cpu_hold); end
        tests_run++; if (nready_cnt - nr != 4096) begin tests_failed++; $display("FAIL full_stall: got %0d want 4096", nready_cnt - nr); end
    endtask

    task automatic test_reset_mid_frame();
        int wb;
        int bad = 0;
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_frame();
        #2 resetn = 1'b0;
        #1;
        tests_run++; if (rx_ready !== 1'b1 || ram_ce !== 1'b0 || ram_wre !== 1'b0 || ram_ad !== 12'd0 || ram_din !== 32'd0) begin tests_failed++; $display("FAIL mid_rst_bus: got rdy=%b ce=%b wre=%b ad=%h din=%h want 1 0 0 0 0", rx_ready, ram_ce, ram_wre, ram_ad, ram_din); end
        tests_run++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || words_loaded !== 13'd0) begin tests_failed++; $display("FAIL mid_rst_status: got hold=%b done=%b err=%b wl=%0d want 1 0 0 0", cpu_hold, load_done, load_err, words_loaded); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        wb = wad_q.size();
        build_frame(3, 1'b0, 1'b0);
        send_frame();
        tests_run++; if (wad_q.size() - wb != 3) begin tests_failed++; $display("FAIL mid_rst_wcount: got %0d want 3", wad_q.size() - wb); end
        for (int k = 0; k < 3 && wb + k < wad_q.size(); k++)
            if (wad_q[wb+k] !== 12'(k) || wdin_q[wb+k] !== model_word(k)) bad++;
        tests_run++; if (bad != 0 || load_done !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_reload: got %0d wrong words done=%b want 0 1", bad, load_done); end
    endtask

    initial begin
        test_reset();
        test_directed(8'h27, 1'b1);
        test_directed(8'h28, 1'b0);
        test_len_errors();
        test_timeout();
        test_back_to_back();
        test_full_load();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_ram_loader.md
Name: instr_ram_loader

Overview:
Boot-time writer for the 32-bit x 4096-word single-port instruction RAM. It receives a framed byte stream from the debug UART receiver and assembles the bytes into little-endian 32-bit words. It writes the words to consecutive RAM addresses from 0, checks a frame checksum, and holds the CPU in reset until a load completes. The top level muxes the RAM port between this block (cpu_hold=1) and instruction fetch (cpu_hold=0).

Parameters:
ADDR_W, 12, RAM word-address width; max words = 2^ADDR_W
DATA_W, 32, RAM word width; fixed at 32 (4 bytes per word)
MAGIC, 8'hA5, frame start byte
TIMEOUT, 1000000, idle cycles allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_valid  in  1  byte available from UART receiver
rx_data  in  8  received byte
rx_ready  out  1  loader accepts byte; transfer when rx_valid & rx_ready
ram_ce  out  1  RAM clock enable (write strobe qualifier)
ram_wre  out  1  RAM write enable
ram_ad  out  ADDR_W  RAM word address
ram_din  out  32  RAM write data
cpu_hold  out  1  hold CPU in reset and select loader on RAM port
load_done  out  1  last frame loaded and checksum matched
load_err  out  1  last frame aborted
words_loaded  out  ADDR_W+1  words written in current/last frame

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: state=IDLE, rx_ready=1, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0, checksum=0, timeout counter=0.
- Frame format: MAGIC, LEN_LO, LEN_HI, then 4*N payload bytes (word k = bytes b0..b3, b0 in [7:0]), then CSUM. N = {LEN_HI,LEN_LO}. CSUM = 8-bit sum mod 256 of all payload bytes.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR: rx_ready=1. A byte equal to MAGIC goes to LEN0 on the same clock edge. It sets cpu_hold=1, clears load_done/load_err/words_loaded/checksum, and sets ram_ad=0. Other bytes are discarded and the state is unchanged.
- LEN0 -> LEN1 on accepted byte (stores LEN_LO). LEN1 -> on accepted byte, if N==0 or N>2^ADDR_W goes to ERR, else goes to DATA with byte index=0.
- DATA: each accepted byte goes into lane [8*idx+:8], and the byte is added to checksum. On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - ram_ce=1, ram_wre=1, ram_ad=current address, ram_din=assembled word; rx_ready=0 in this cycle.
  - Next cycle: ram_ce=ram_wre=0, words_loaded+1, ram_ad+1.
  - Go to CSUM if words_loaded+1==N, else back to DATA.
- ram_ce/ram_wre are high only in WRITE; RAM write latency is one edge.
- CSUM: on accepted byte, if byte==checksum go to DONE (load_done=1, cpu_hold=0); else go to ERR (load_err=1, cpu_hold stays 1).
- ERR does not erase RAM contents already written.
- Timeout: in LEN0/LEN1/DATA/CSUM, a counter increments on every cycle with no accepted byte and clears on each accepted byte. On reaching TIMEOUT it goes to ERR (load_err=1). The counter is idle (0) in other states.
- rx_ready stays 1 in all states except WRITE, so the UART is back-pressured for at most 1 cycle per word.
- Address wrap: ram_ad never wraps within a frame, because N <= 2^ADDR_W. When N=4096, ram_ad returns to 0 after the last write; words_loaded=4096 needs ADDR_W+1 bits.
- MAGIC inside LEN/DATA/CSUM is ordinary data, not a restart.
- Reset mid-frame: all state returns to reset values immediately. A partially written RAM is left as is; cpu_hold=1.

Test Plan:
- Frame A5 02 00, payload 13 00 00 00 / 78 56 34 12, CSUM 0x127 mod 256 = 0x27 -> two WRITE cycles: ad=0 din=32'h00000013, then ad=1 din=32'h12345678. Then load_done=1, cpu_hold=0, words_loaded=2.
- Same frame with CSUM 0x28 -> both words written, then load_err=1, load_done=0, cpu_hold=1.
- Bytes 00 FF then A5 00 00 -> first two bytes ignored; LEN=0 gives ERR with load_err=1 and no RAM write. A5 01 10 (N=4097) -> also ERR.
- TIMEOUT=16: A5 01 00 AA, then rx_valid held low for 16 cycles -> ERR with load_err=1; a following valid frame recovers to load_done=1.
- rx_valid held high continuously with back-to-back bytes -> rx_ready low exactly one cycle per word, no byte lost or duplicated. Also N=4096 full load -> last write at ad=4095, words_loaded=4096.
- Assert resetn low during the DATA state of a frame -> all outputs return to reset values asynchronously. A new frame after release loads correctly from address 0.
